// File: rtl/mult_div_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
//   Shared definitions for the iterative multiply/divide unit:
//     - md_state_e   : control FSM states (IDLE, RUN, FIX, DONE)
//     - OP_MULT/OP_DIV : values of op[0]
//     - OP_UNS_BIT   : op bit index selecting unsigned operation
//     - MD_WIDTH     : default operand width
//     - MD_CNT_W     : iteration counter width for the default width
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package mult_div_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int MD_CNT_W   = $clog2(MD_WIDTH);

    localparam logic OP_MULT    = 1'b0;
    localparam logic OP_DIV     = 1'b1;
    localparam int   OP_UNS_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

    // Counter width helper that never returns zero, so a 1-bit unit still
    // gets a legal counter vector.
    function automatic int md_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// ---------------------------------------------------------------------------
// md_iter_core
//   Datapath of the multiply/divide unit. Holds the 2*WIDTH accumulator,
//   the latched divisor/multiplicand magnitude and the operand sign flags.
//   One shift-add (MULT) or restoring-subtract (DIV) step per 'step' cycle.
//   The sign-corrected result is presented combinationally on res_hi/res_lo
//   and is captured by the parent on the edge leaving FIX.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   load          latch operands (start accepted in IDLE)
//   step          perform one iteration
//   div_in        1 = divide, 0 = multiply (sampled on load)
//   signed_in     1 = treat operands as two's complement (sampled on load)
//   a_in, b_in    operands (sampled on load)
//   res_hi/res_lo sign-corrected result (remainder/quotient for DIV)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module md_iter_core
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             div_in,
    input  logic             signed_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd_reg;
    logic               is_div_reg;
    logic               a_neg_reg;
    logic               b_neg_reg;

    logic               a_neg_in;
    logic               b_neg_in;
    logic [WIDTH-1:0]   a_mag_in;
    logic [WIDTH-1:0]   b_mag_in;

    // Upper and lower accumulator halves: product high/low for MULT,
    // partial remainder / quotient-under-construction for DIV.
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;

    logic [2*WIDTH-1:0] prod_fixed;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    assign a_neg_in = signed_in & a_in[WIDTH-1];
    assign b_neg_in = signed_in & b_in[WIDTH-1];
    assign a_mag_in = magnitude(a_in, a_neg_in);
    assign b_mag_in = magnitude(b_in, b_neg_in);

    assign acc_hi = acc_reg[2*WIDTH-1:WIDTH];
    assign acc_lo = acc_reg[WIDTH-1:0];

    // MULT step: add multiplicand into the high half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator
    // right, keeping the carry out of the add.
    assign mul_sum = {1'b0, acc_hi} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);

    // DIV step: shift remainder left pulling in the next dividend bit and
    // trial-subtract the divisor. The remainder is always below the divisor,
    // so the (WIDTH+1)-bit difference never overflows and its MSB is the
    // borrow.
    assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign rem_diff  = rem_shift - {1'b0, opnd_reg};

    always_comb begin
        acc_next = acc_reg;
        if (is_div_reg) begin
            if (!rem_diff[WIDTH])
                acc_next = {rem_diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
            else
                acc_next = {rem_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
        end else begin
            acc_next = {mul_sum, acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg    <= '0;
            opnd_reg   <= '0;
            is_div_reg <= 1'b0;
            a_neg_reg  <= 1'b0;
            b_neg_reg  <= 1'b0;
        end else if (load) begin
            acc_reg    <= {{WIDTH{1'b0}}, a_mag_in};
            opnd_reg   <= b_mag_in;
            is_div_reg <= div_in;
            a_neg_reg  <= a_neg_in;
            b_neg_reg  <= b_neg_in;
        end else if (step) begin
            acc_reg    <= acc_next;
        end
    end

    // Sign correction. Product and quotient are negative when the operand
    // signs differ; the remainder follows the dividend's sign.
    assign prod_fixed = (a_neg_reg ^ b_neg_reg) ? (~acc_reg + 1'b1) : acc_reg;

    always_comb begin
        res_hi = prod_fixed[2*WIDTH-1:WIDTH];
        res_lo = prod_fixed[WIDTH-1:0];
        if (is_div_reg) begin
            res_hi = magnitude(acc_hi, a_neg_reg);
            res_lo = magnitude(acc_lo, a_neg_reg ^ b_neg_reg);
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative MULT/DIV unit with Hi/Lo result registers and a start/busy/done
//   handshake. Signed by default; when MULT_DIV_UNSIGNED_EN is defined,
//   op[1]=1 selects MULTU/DIVU.
//
// Ports
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     begin an operation (only honoured in IDLE)
//   op[1:0]   op[0]: 0=MULT, 1=DIV; op[1]: unsigned select (feature build)
//   a, b      operands (multiplicand/dividend, multiplier/divisor)
//   hi, lo    result registers
//   busy      high whenever the FSM is not in IDLE
//   done      one-cycle completion pulse (also on divide-by-zero abort)
//   div_zero  sticky divide-by-zero flag, cleared by the next accepted start
//
// Timing: normal ops show done WIDTH+2 cycles after the start edge
// (WIDTH RUN cycles, one FIX, one DONE); divide-by-zero shows done at once.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = md_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    md_state_e         state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [WIDTH-1:0]  hi_reg;
    logic [WIDTH-1:0]  lo_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              div_zero_reg;

    logic              is_signed;
    logic              accept;
    logic              div_by_zero;
    logic              core_load;
    logic              core_step;
    logic [WIDTH-1:0]  core_hi;
    logic [WIDTH-1:0]  core_lo;

`ifdef MULT_DIV_UNSIGNED_EN
    assign is_signed = ~op[OP_UNS_BIT];
`else
    // Every operation is signed; the unsigned select bit is intentionally
    // left unconnected.
    logic op_uns_unused;
    assign op_uns_unused = op[OP_UNS_BIT];
    assign is_signed     = 1'b1;
`endif

    assign accept      = (state_reg == IDLE) && start;
    assign div_by_zero = (op[0] == OP_DIV) && (b == '0);
    assign core_load   = accept && !div_by_zero;
    assign core_step   = (state_reg == RUN);

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .div_in    (op[0]),
        .signed_in (is_signed),
        .a_in      (a),
        .b_in      (b),
        .res_hi    (core_hi),
        .res_lo    (core_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        busy_reg     <= 1'b1;
                        div_zero_reg <= div_by_zero;
                        cnt_reg      <= '0;
                        if (div_by_zero) begin
                            // Abort straight to DONE; hi/lo keep old values.
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST)
                        state_reg <= FIX;
                end
                FIX: begin
                    hi_reg    <= core_hi;
                    lo_reg    <= core_lo;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign hi       = hi_reg;
    assign lo       = lo_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
`timescale 1ns/1ps

module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          busy;
    logic          done;
    logic          div_zero;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        string        name;
    } exp_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad   = 0;
    int           done_cnt = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural rules.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] av,
                                   input logic [W-1:0] bv, input string name);
        exp_t        e;
        logic        uns;
        longint      sa, sb, sp, sq, sr;
        logic [63:0] up;
        uns = 1'b0;
`ifdef MULT_DIV_UNSIGNED_EN
        uns = o[1];
`endif
        e.name = name;
        e.dz   = 1'b0;
        e.hi   = model_hi;
        e.lo   = model_lo;
        sa = uns ? longint'({32'd0, av}) : longint'($signed(av));
        sb = uns ? longint'({32'd0, bv}) : longint'($signed(bv));
        if (o[0] == 1'b0) begin
            if (uns) begin
                up = {32'd0, av} * {32'd0, bv};
            end else begin
                sp = sa * sb;
                up = sp;
            end
            e.hi = up[63:32];
            e.lo = up[31:0];
        end else if (bv == '0) begin
            e.dz = 1'b1;
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            e.lo = sq[31:0];
            e.hi = sr[31:0];
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                check({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                check({e.name, "_dz"}, 64'(div_zero), 64'(e.dz));
                $display("op %s: hi=%h lo=%h div_zero=%0b", e.name, hi, lo, div_zero);
            end
        end
    end

    // Issue one operation and follow it to completion. noise_cyc > 0 pulses
    // start (with other operands) at that cycle while the unit is busy.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input string name, input int noise_cyc);
        exp_t e;
        int   lat;
        int   exp_lat;
        e = model(o, av, bv, name);
        model_hi = e.hi;
        model_lo = e.lo;
        sb_q.push_back(e);
        exp_lat = e.dz ? 1 : W + 2;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (noise_cyc > 0 && lat == noise_cyc) begin
                start = 1'b1; op = 2'b01; a = 32'd100; b = 32'd7;
            end
            if (noise_cyc > 0 && lat == noise_cyc + 1) start = 1'b0;
            if (lat == 1) check({name, "_busy_c1"}, 64'(busy), 64'd1);
            if (done) break;
            if (lat > 100) begin
                total++; bad++;
                $display("FAIL %s_timeout: got no done after %0d cycles expected %0d", name, lat, exp_lat);
                break;
            end
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_dz", 64'(div_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op(2'b00, 32'd7, 32'hFFFF_FFFD, "mult_7_m3", 0);
        check("mult_7_m3_hi_abs", 64'(hi), 64'hFFFF_FFFF);
        check("mult_7_m3_lo_abs", 64'(lo), 64'hFFFF_FFEB);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min_min", 0);
        check("mult_min_min_hi_abs", 64'(hi), 64'h4000_0000);
        do_op(2'b01, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 0);
        check("div_m7_2_lo_abs", 64'(lo), 64'hFFFF_FFFD);
        check("div_m7_2_hi_abs", 64'(hi), 64'hFFFF_FFFF);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", 0);
        check("div_min_m1_lo_abs", 64'(lo), 64'h8000_0000);
        do_op(2'b01, 32'h451, 32'h20, "div_setup", 0);
        do_op(2'b01, 32'd5, 32'd0, "div_by_zero", 0);
        check("div_by_zero_hi_abs", 64'(hi), 64'h11);
        check("div_by_zero_lo_abs", 64'(lo), 64'h22);
        do_op(2'b00, 32'd2, 32'd3, "mult_2_3", 0);
        check("mult_2_3_lo_abs", 64'(lo), 64'd6);
        do_op(2'b10, 32'hFFFF_FFFF, 32'd2, "multu_opt", 0);
        do_op(2'b01, 32'd1000, 32'hFFFF_FFF3, "div_noise", 10);

        // Reset in the middle of a divide: immediate clear, no done pulse.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'd12345; b = 32'd17;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        model_hi = '0;
        model_lo = '0;
        begin
            int dc;
            dc = done_cnt;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            repeat (40) @(negedge clk);
            check("midrst_no_done", 64'(done_cnt), 64'(dc));
        end

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 20)) - 32'd10;
            do_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), 0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
